// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage register usage in, forwarding selects / interlock / stall count out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       drs;
  logic [4:0]       drt;
  logic             duse_rs;
  logic             duse_rt;
  logic             dwreg;
  logic             dm2reg;
  logic [4:0]       drn;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             wpcir;
  logic             dbubble;
  logic             ewreg_s;
  logic             em2reg_s;
  logic [4:0]       ern_s;
  logic             mwreg_s;
  logic             mm2reg_s;
  logic [4:0]       mrn_s;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn,
    input  fwda, fwdb, wpcir, dbubble,
           ewreg_s, em2reg_s, ern_s, mwreg_s, mm2reg_s, mrn_s, stall_cnt
  );

  modport slave (
    input  drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn,
    output fwda, fwdb, wpcir, dbubble,
           ewreg_s, em2reg_s, ern_s, mwreg_s, mm2reg_s, mrn_s, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use interlock and E/M forwarding control with shadow E/M write-back
// fields and a saturating stall-cycle counter.
module pipe_hazard_lane (
  input  logic       use_i,
  input  logic [4:0] rn_i,
  input  logic       ewreg_i,
  input  logic       em2reg_i,
  input  logic [4:0] ern_i,
  input  logic       mwreg_i,
  input  logic       mm2reg_i,
  input  logic [4:0] mrn_i,
  output logic       e_hit_o,
  output logic [1:0] sel_o
);
  logic m_hit;

  // r0 is hardwired zero, so a zero destination never matches
  assign e_hit_o = use_i & ewreg_i & (ern_i != 5'd0) & (ern_i == rn_i);
  assign m_hit   = use_i & mwreg_i & (mrn_i != 5'd0) & (mrn_i == rn_i);

  always_comb begin
    sel_o = 2'b00;
    if (e_hit_o && !em2reg_i) sel_o = 2'b01;
    else if (m_hit)           sel_o = mm2reg_i ? 2'b11 : 2'b10;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              clrn,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int NUM_OPS = 2;

  logic             ewreg_q, ewreg_d;
  logic             em2reg_q, em2reg_d;
  logic [4:0]       ern_q, ern_d;
  logic             mwreg_q, mwreg_d;
  logic             mm2reg_q, mm2reg_d;
  logic [4:0]       mrn_q, mrn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_OPS-1:0][4:0] op_rn;
  logic [NUM_OPS-1:0]      op_use;
  logic [NUM_OPS-1:0]      op_ehit;
  logic [NUM_OPS-1:0][1:0] op_sel;
  logic                    lu;

  assign op_rn  = {bus.drt, bus.drs};
  assign op_use = {bus.duse_rt, bus.duse_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    pipe_hazard_lane u_lane (
      .use_i    (op_use[g]),
      .rn_i     (op_rn[g]),
      .ewreg_i  (ewreg_q),
      .em2reg_i (em2reg_q),
      .ern_i    (ern_q),
      .mwreg_i  (mwreg_q),
      .mm2reg_i (mm2reg_q),
      .mrn_i    (mrn_q),
      .e_hit_o  (op_ehit[g]),
      .sel_o    (op_sel[g])
    );
  end

  // Only a load still in E cannot be forwarded; both operands share one stall
  assign lu = (|op_ehit) & em2reg_q;

  always_comb begin
    mwreg_d  = ewreg_q;
    mm2reg_d = em2reg_q;
    mrn_d    = ern_q;
    ewreg_d  = lu ? 1'b0 : bus.dwreg;
    em2reg_d = lu ? 1'b0 : bus.dm2reg;
    ern_d    = lu ? 5'd0 : bus.drn;
    cnt_d    = cnt_q;
    if (lu && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ewreg_q  <= 1'b0;
      em2reg_q <= 1'b0;
      ern_q    <= 5'd0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mrn_q    <= 5'd0;
      cnt_q    <= '0;
    end else begin
      ewreg_q  <= ewreg_d;
      em2reg_q <= em2reg_d;
      ern_q    <= ern_d;
      mwreg_q  <= mwreg_d;
      mm2reg_q <= mm2reg_d;
      mrn_q    <= mrn_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.fwda      = op_sel[0];
  assign bus.fwdb      = op_sel[1];
  assign bus.wpcir     = ~lu;
  assign bus.dbubble   = lu;
  assign bus.ewreg_s   = ewreg_q;
  assign bus.em2reg_s  = em2reg_q;
  assign bus.ern_s     = ern_q;
  assign bus.mwreg_s   = mwreg_q;
  assign bus.mm2reg_s  = mm2reg_q;
  assign bus.mrn_s     = mrn_q;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a 16-bit-counter and a 2-bit-counter instance
// driven with identical ID streams, checked against a queue of expectations.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic clrn;

  pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  ifb ();

  pipe_hazard_ctrl #(.CNT_W(16)) u_dut_a (.clk(clk), .clrn(clrn), .bus(ifa.slave));
  pipe_hazard_ctrl #(.CNT_W(2))  u_dut_b (.clk(clk), .clrn(clrn), .bus(ifb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ctl = {fwda, fwdb, wpcir, dbubble}; cnt = stall cycles before this edge
  typedef struct {
    string      nm;
    logic [5:0] ctl;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   n_stalls;

  localparam logic [5:0] IDLE = 6'b0000_10;

  function automatic logic [18:0] ins(bit ur, int rs, bit ut, int rt, bit w, bit m, int rn);
    return {ur, 5'(rs), ut, 5'(rt), w, m, 5'(rn)};
  endfunction

  task automatic drive(input logic [18:0] s);
    {ifa.duse_rs, ifa.drs, ifa.duse_rt, ifa.drt, ifa.dwreg, ifa.dm2reg, ifa.drn} = s;
    {ifb.duse_rs, ifb.drs, ifb.duse_rt, ifb.drt, ifb.dwreg, ifb.dm2reg, ifb.drn} = s;
  endtask

  task automatic test_reset;
    exp_t e;
    clrn = 1'b0;
    drive(19'($urandom));
    @(posedge clk); #1;
    drive(19'($urandom));
    @(posedge clk);
    sb.push_back('{"reset", IDLE, 0});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble} !== e.ctl) begin
      errors++;
      $display("FAIL reset_ctl: got %b want %b", {ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble}, e.ctl);
    end
    checks++;
    if ({ifa.ewreg_s, ifa.em2reg_s, ifa.ern_s, ifa.mwreg_s, ifa.mm2reg_s, ifa.mrn_s} !== 14'd0 ||
        ifa.stall_cnt !== 16'(e.cnt) || ifb.stall_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: shadows %b cnt %0d/%0d want all 0",
               {ifa.ewreg_s, ifa.em2reg_s, ifa.ern_s, ifa.mwreg_s, ifa.mm2reg_s, ifa.mrn_s},
               ifa.stall_cnt, ifb.stall_cnt);
    end
    drive(19'd0);
    @(posedge clk); #1;
    clrn = 1'b1;
    n_stalls = 0;
  endtask

  // Shared step body is written out per task so each owns its comparisons
  task automatic test_alu_chain;
    logic [18:0] st [5];
    logic [5:0]  ex [5];
    exp_t e;
    st = '{ins(0,0,0,0,1,0,3), ins(1,3,1,3,0,0,0), ins(1,3,0,0,0,0,0), 19'd0, 19'd0};
    ex = '{IDLE, 6'b01_01_10, 6'b10_00_10, IDLE, IDLE};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      sb.push_back('{$sformatf("alu_chain[%0d]", i), ex[i], n_stalls});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble} !== e.ctl) begin
        errors++;
        $display("FAIL %s: ctl got %b want %b", e.nm, {ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble}, e.ctl);
      end
      if (e.ctl[0]) n_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use(input int rt, input bit both);
    logic [18:0] st [5];
    logic [5:0]  ex [5];
    exp_t e;
    st = '{ins(0,0,0,0,1,1,rt), ins(both,rt,1,rt,1,0,6), ins(both,rt,1,rt,1,0,6), 19'd0, 19'd0};
    ex = '{IDLE, 6'b00_00_01, {both ? 2'b11 : 2'b00, 4'b11_10}, IDLE, IDLE};
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      sb.push_back('{$sformatf("load_use_r%0d[%0d]", rt, i), ex[i], n_stalls});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble} !== e.ctl) begin
        errors++;
        $display("FAIL %s: ctl got %b want %b", e.nm, {ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble}, e.ctl);
      end
      checks++;
      if (ifa.stall_cnt !== 16'(e.cnt) || ifb.stall_cnt !== ((e.cnt > 3) ? 2'd3 : 2'(e.cnt))) begin
        errors++;
        $display("FAIL %s_cnt: got %0d/%0d want %0d (sat 3)", e.nm, ifa.stall_cnt, ifb.stall_cnt, e.cnt);
      end
      if (i == 2) begin
        checks++;
        if ({ifa.ewreg_s, ifa.ern_s, ifa.mwreg_s, ifa.mm2reg_s, ifa.mrn_s} !== {1'b0, 5'd0, 2'b11, 5'(rt)}) begin
          errors++;
          $display("FAIL %s_shadow: got %b want %b", e.nm,
                   {ifa.ewreg_s, ifa.ern_s, ifa.mwreg_s, ifa.mm2reg_s, ifa.mrn_s}, {1'b0, 5'd0, 2'b11, 5'(rt)});
        end
      end
      if (e.ctl[0]) n_stalls++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reg0_nonuse;
    logic [18:0] st [6];
    logic [5:0]  ex [6];
    exp_t e;
    st = '{ins(0,0,0,0,1,1,0), ins(1,0,1,0,0,0,0), ins(0,0,0,0,1,0,7),
           ins(0,0,0,7,0,0,0), 19'd0, 19'd0};
    ex = '{IDLE, IDLE, IDLE, IDLE, IDLE, IDLE};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      sb.push_back('{$sformatf("reg0_nonuse[%0d]", i), ex[i], n_stalls});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble} !== e.ctl) begin
        errors++;
        $display("FAIL %s: ctl got %b want %b", e.nm, {ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble}, e.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority;
    logic [18:0] st [6];
    logic [5:0]  ex [6];
    exp_t e;
    // E holds ALU r4 over M load r4; then E ALU r8 on rs with M ALU r4 on rt
    st = '{ins(0,0,0,0,1,1,4), ins(0,0,0,0,1,0,4), ins(1,4,0,0,1,0,8),
           ins(1,8,1,4,0,0,0), 19'd0, 19'd0};
    ex = '{IDLE, IDLE, 6'b01_00_10, 6'b01_10_10, IDLE, IDLE};
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      sb.push_back('{$sformatf("priority[%0d]", i), ex[i], n_stalls});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble} !== e.ctl) begin
        errors++;
        $display("FAIL %s: ctl got %b want %b", e.nm, {ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble}, e.ctl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 5; k++) test_load_use(5 + k, k[0]);
    checks++;
    if (ifb.stall_cnt !== 2'd3 || ifa.stall_cnt !== 16'(n_stalls)) begin
      errors++;
      $display("FAIL saturation: got %0d/%0d want 3/%0d", ifb.stall_cnt, ifa.stall_cnt, n_stalls);
    end
  endtask

  task automatic test_mid_stall_reset;
    exp_t e;
    drive(ins(0,0,0,0,1,1,5));
    @(posedge clk); #1;
    drive(ins(0,0,1,5,1,0,6));
    sb.push_back('{"mid_reset_stall", 6'b00_00_01, n_stalls});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble} !== e.ctl) begin
      errors++;
      $display("FAIL %s: ctl got %b want %b", e.nm, {ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble}, e.ctl);
    end
    clrn = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b1;
    n_stalls = 0;
    sb.push_back('{"mid_reset_after", IDLE, 0});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble} !== e.ctl) begin
      errors++;
      $display("FAIL %s: ctl got %b want %b", e.nm, {ifa.fwda, ifa.fwdb, ifa.wpcir, ifa.dbubble}, e.ctl);
    end
    checks++;
    if ({ifa.ewreg_s, ifa.em2reg_s, ifa.ern_s, ifa.mwreg_s, ifa.mm2reg_s, ifa.mrn_s} !== 14'd0 ||
        ifa.stall_cnt !== 16'(e.cnt) || ifb.stall_cnt !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_state: shadows %b cnt %0d/%0d want all 0",
               {ifa.ewreg_s, ifa.em2reg_s, ifa.ern_s, ifa.mwreg_s, ifa.mm2reg_s, ifa.mrn_s},
               ifa.stall_cnt, ifb.stall_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    n_stalls = 0;
    clrn     = 1'b0;
    drive(19'd0);
    test_reset;
    test_alu_chain;
    test_load_use(5, 1'b0);
    test_load_use(9, 1'b1);
    test_reg0_nonuse;
    test_priority;
    test_saturation;
    test_mid_stall_reset;
    test_alu_chain;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Interlock and forwarding controller for the 5-stage pipelined CPU, sitting beside the ID/EXE and EXE/MEM pipeline registers.
- It receives each decoded instruction's register usage in ID and keeps a shadow copy of the E and M stage write-back fields.
- From these it drives forwarding selects for both ID operands, a load-use stall, and a bubble-insert control for the ID/EXE register.
- It also counts stall cycles for performance monitoring.

Parameters:
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  clock, all state updates on posedge
clrn  input  1  reset, active-low, synchronous
drs  input  5  ID rs field
drt  input  5  ID rt field
duse_rs  input  1  ID instruction reads rs
duse_rt  input  1  ID instruction reads rt
dwreg  input  1  ID instruction writes register file
dm2reg  input  1  ID instruction is a load
drn  input  5  ID destination register
fwda  output  2  rs operand select: 00 regfile, 01 E ALU result, 10 M ALU result, 11 M memory data
fwdb  output  2  rt operand select, same encoding as fwda
wpcir  output  1  0 = freeze PC and IF/ID register this cycle
dbubble  output  1  1 = ID/EXE register must capture dwreg=0, dwmem=0 (bubble)
ewreg_s, em2reg_s  output  1 each  shadow E-stage write-enable / load flag
ern_s  output  5  shadow E-stage destination
mwreg_s, mm2reg_s  output  1 each  shadow M-stage write-enable / load flag
mrn_s  output  5  shadow M-stage destination
stall_cnt  output  CNT_W  total load-use stall cycles since reset

Behaviour:
- Reset: synchronous; sampled on posedge clk with clrn==0.
  - All shadow registers and stall_cnt are set to 0.
  - Outputs settle to fwda=fwdb=00, wpcir=1, dbubble=0.
  - Reset takes priority over every other update. A stall in progress is dropped, and the shadow stages become empty.
- Hazard match, combinational, per operand X in {rs, rt} with register rX:
  - eX = duse_X & ewreg_s & (ern_s!=0) & (ern_s==rX)
  - mX = duse_X & mwreg_s & (mrn_s!=0) & (mrn_s==rX)
- Load-use stall, combinational: lu = (eRS & em2reg_s) | (eRT & em2reg_s).
  - wpcir = ~lu
  - dbubble = lu
- Forward select, combinational, E has priority over M:
  - If eX & ~em2reg_s: 01.
  - Else if mX: 11 when mm2reg_s, else 10.
  - Otherwise: 00.
  - During lu the selects still take these values; they are don't-care to the datapath.
- Register 0 never matches: a destination of 0 never forwards or stalls.
- Shadow pipeline, updated each posedge when clrn==1:
  - M shadow takes the E shadow values: mwreg_s <= ewreg_s, mm2reg_s <= em2reg_s, mrn_s <= ern_s.
  - If lu: ewreg_s <= 0, em2reg_s <= 0, ern_s <= 0. This is the bubble.
  - Else: ewreg_s <= dwreg, em2reg_s <= dm2reg, ern_s <= drn.
- Latency: a load-use stall lasts exactly 1 cycle.
  - In the following cycle the load is in the M shadow and the dependent operand selects 11.
- stall_cnt increments by 1 on every posedge with lu=1 and clrn=1.
  - It saturates at all ones and never wraps.
- Simultaneous conditions:
  - rs and rt both hazard on the same E-stage load: one stall cycle, counter +1.
  - drs==drt: both selects are identical.
  - E and M write the same register: E wins.
- No internal state beyond the shadow registers and stall_cnt. All hazard decode is combinational from the registered state and the current ID inputs.

Test Plan:
- Reset: hold clrn=0 for 2 clocks with random inputs.
  - Required: all shadow outputs 0, stall_cnt=0, wpcir=1, dbubble=0, fwda=fwdb=00.
- ALU-ALU forward chain: add r3 (dwreg=1, drn=3) then an instruction using rs=3, rt=3.
  - Next cycle: fwda=fwdb=01.
  - One cycle later, a user of rs=3: fwda=10.
- Load-use: lw r5 (dm2reg=1, drn=5) followed immediately by a use of rt=5.
  - First cycle: wpcir=0, dbubble=1, stall_cnt goes 0→1.
  - Next cycle, same ID inputs held: ewreg_s=0, wpcir=1, fwdb=11.
- Register 0 and non-use:
  - Writer with drn=0 followed by a use of rs=0: fwda=00, no stall.
  - Writer r7 followed by an instruction with duse_rt=0, drt=7: fwdb=00.
- Priority: E writes r4 (ALU) and M writes r4 (load); ID uses rs=4.
  - Required: fwda=01, not 11.
- Saturation and mid-stall reset:
  - With CNT_W=2, force 5 consecutive load-use stalls: stall_cnt stays at 3.
  - Assert clrn=0 during a stall cycle: next cycle all shadows are 0 and wpcir=1.
